pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Parametrised hazard/flow controller for an NSTAGES in-order pipeline.
//  - Sequences post-reset drain so every stage holds a NOP before fetch runs.
//  - Detects load-use stalls, EX-stage redirects (branch/jump) and external memory-busy freezes.
//  - Generates per-boundary enable/flush vectors, PC control and rs1/rs2 forwarding selects.
// PARAMETERS
//  NSTAGES    5  pipeline stages; boundaries = NSTAGES-1 (bit0 = IF/DE, bit NSTAGES-2 = last)
//  REG_ADDR_W 5  register-index width
//  DRAIN_CYC  NSTAGES-1  cycles of forced flush after reset release (>=1)
//  CNT_W      32 perf-counter width (used only with HAZARD_PERF_CNT_EN)
// PORTS
//  CLK          in  1             clock, rising edge
//  RST          in  1             synchronous reset, active-low
//  de_rs1       in  REG_ADDR_W    DE-stage source 1 index
//  de_rs2       in  REG_ADDR_W    DE-stage source 2 index
//  ex_rd        in  REG_ADDR_W    EX-stage destination index
//  ex_mem_rd    in  1             EX instruction is a load
//  mem_rd       in  REG_ADDR_W    MEM-stage destination index
//  mem_we       in  1             MEM instruction writes regfile
//  wb_rd        in  REG_ADDR_W    WB-stage destination index
//  wb_we        in  1             WB instruction writes regfile
//  ex_redirect  in  1             EX resolved taken branch/jump
//  mem_busy     in  1             data/instr memory not ready this cycle
//  pc_enable    out 1             PC register load enable
//  pc_sel       out 1             0 = sequential PC, 1 = EX redirect target
//  stg_en       out NSTAGES-1     boundary register enables
//  stg_fl       out NSTAGES-1     boundary register flush (load NOP)
//  fwd_a/fwd_b  out 2             00 regfile, 01 from MEM, 10 from WB
//  stall_cnt/flush_cnt out CNT_W  perf counters (present only with macro)
// BEHAVIOUR
//  - FSM (registered): RESET -> DRAIN -> RUN. RST=0 forces RESET next edge from any state.
//    RESET: RST=1 -> DRAIN, drain counter cleared. DRAIN: counter++ per cycle; at DRAIN_CYC-1 -> RUN.
//    RST asserted mid-DRAIN/RUN: RESET next edge; counter cleared.
//  - Outputs combinational from FSM state + inputs; no extra latency.
//  - RESET/DRAIN: pc_enable=0 in RESET, 1 in DRAIN; stg_en=all 1; stg_fl bit0=0,
//    all others=1; pc_sel=0; fwd=00; memory-busy/hazards ignored.
//  - RUN priority (highest first):
//    1 mem_busy: pc_enable=0, stg_en=all 0, stg_fl=all 0 (full freeze, redirect held by EX).
//    2 ex_redirect: pc_enable=1, pc_sel=1, stg_fl[0]=stg_fl[1]=1, others 0; stg_en=all 1.
//    3 load-use (ex_mem_rd & ex_rd!=0 & (ex_rd==de_rs1 | ex_rd==de_rs2)):
//      pc_enable=0, stg_en[0]=0, stg_fl[1]=1 (bubble into EX), rest enabled, pc_sel=0.
//    4 none: pc_enable=1, pc_sel=0, stg_en=all 1, stg_fl=all 0.
//  - Forwarding (RUN only, independent of priority): per source rs:
//    rs==0 -> 00; mem_we & mem_rd==rs -> 01; else wb_we & wb_rd==rs -> 10; else 00.
//    MEM beats WB when both match.
//  - Redirect + load-use same cycle: redirect wins (DE is wrong-path).
//  - NSTAGES<3 illegal: elaboration $error.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cnt/flush_cnt ports exist; stall_cnt += 1 each RUN cycle
//    with case 1 or 3; flush_cnt += 1 each RUN cycle with case 2; both saturate at all-ones;
//    both cleared to 0 on reset, not counted in RESET/DRAIN.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  RST=0 3 cycles, release; NSTAGES=5 -> stg_fl=4'b1110 for 4 cycles, then 4'b0000; pc_enable 0 in RESET.
//  RUN, ex_mem_rd=1 ex_rd=5 de_rs2=5 -> pc_enable=0, stg_en=4'b1110, stg_fl=4'b0010 same cycle.
//  ex_redirect=1 with same load-use -> pc_sel=1, pc_enable=1, stg_fl=4'b0011, stg_en=4'b1111.
//  mem_busy=1 with ex_redirect=1 -> stg_en=0, pc_enable=0; drop mem_busy -> redirect outputs next cycle.
//  de_rs1=7, mem_rd=7 mem_we=1, wb_rd=7 wb_we=1 -> fwd_a=01; de_rs1=0 same writers -> fwd_a=00.
//  Macro on: 3 load-use + 2 redirect cycles -> stall_cnt=3, flush_cnt=2; RST=0 mid-RUN -> both 0, FSM RESET.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle between pipeline datapath (master) and controller (slave).
// Perf-counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int NSTAGES    = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] de_rs1;
  logic [REG_ADDR_W-1:0] de_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_rd;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_we;
  logic                  ex_redirect;
  logic                  mem_busy;
  logic                  pc_enable;
  logic                  pc_sel;
  logic [NSTAGES-2:0]    stg_en;
  logic [NSTAGES-2:0]    stg_fl;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output de_rs1, de_rs2, ex_rd, ex_mem_rd, mem_rd, mem_we, wb_rd, wb_we,
           ex_redirect, mem_busy,
    input  pc_enable, pc_sel, stg_en, stg_fl, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
  modport slave (
    input  de_rs1, de_rs2, ex_rd, ex_mem_rd, mem_rd, mem_we, wb_rd, wb_we,
           ex_redirect, mem_busy,
    output pc_enable, pc_sel, stg_en, stg_fl, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
`else
  modport master (
    output de_rs1, de_rs2, ex_rd, ex_mem_rd, mem_rd, mem_we, wb_rd, wb_we,
           ex_redirect, mem_busy,
    input  pc_enable, pc_sel, stg_en, stg_fl, fwd_a, fwd_b
  );
  modport slave (
    input  de_rs1, de_rs2, ex_rd, ex_mem_rd, mem_rd, mem_we, wb_rd, wb_we,
           ex_redirect, mem_busy,
    output pc_enable, pc_sel, stg_en, stg_fl, fwd_a, fwd_b
  );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flow controller for an NSTAGES in-order pipeline: post-reset drain, stalls,
// redirects, memory freezes and forwarding selects. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int NSTAGES    = 5,
  parameter int REG_ADDR_W = 5,
  parameter int DRAIN_CYC  = NSTAGES - 1,
  parameter int CNT_W      = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  pipeline_hazard_ctrl_if.slave  hz
);
  localparam int NB = NSTAGES - 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {ST_RESET, ST_DRAIN, ST_RUN} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [NB-1:0]   drain_fl;
  logic            load_use;

  if (NSTAGES < 3) begin : g_bad_nstages
    $error("pipeline_hazard_ctrl: NSTAGES must be >= 3");
  end
  if (DRAIN_CYC < 1) begin : g_bad_drain
    $error("pipeline_hazard_ctrl: DRAIN_CYC must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("pipeline_hazard_ctrl: CNT_W must be >= 1");
  end

  // While draining, IF/DE keeps loading so fetch output lands; every later boundary loads NOP.
  for (genvar gi = 0; gi < NB; gi++) begin : g_drain_fl
    assign drain_fl[gi] = (gi != 0);
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] m_rd, input logic m_we,
    input logic [REG_ADDR_W-1:0] w_rd, input logic w_we
  );
    if (rs == '0)                 return 2'b00;
    else if (m_we && m_rd == rs)  return 2'b01;
    else if (w_we && w_rd == rs)  return 2'b10;
    else                          return 2'b00;
  endfunction

  assign load_use = hz.ex_mem_rd && (hz.ex_rd != '0) &&
                    ((hz.ex_rd == hz.de_rs1) || (hz.ex_rd == hz.de_rs2));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg     <= ST_RESET;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    hz.pc_enable   = 1'b0;
    hz.pc_sel      = 1'b0;
    hz.stg_en      = '1;
    hz.stg_fl      = drain_fl;
    hz.fwd_a       = 2'b00;
    hz.fwd_b       = 2'b00;
    case (state_reg)
      ST_RESET: begin
        drain_cnt_next = '0;
        state_next     = ST_DRAIN;
      end
      ST_DRAIN: begin
        hz.pc_enable = 1'b1;
        if (drain_cnt_reg == DW'(DRAIN_CYC - 1)) state_next = ST_RUN;
        else                                     drain_cnt_next = drain_cnt_reg + 1'b1;
      end
      ST_RUN: begin
        hz.stg_fl = '0;
        hz.fwd_a  = fwd_sel(hz.de_rs1, hz.mem_rd, hz.mem_we, hz.wb_rd, hz.wb_we);
        hz.fwd_b  = fwd_sel(hz.de_rs2, hz.mem_rd, hz.mem_we, hz.wb_rd, hz.wb_we);
        if (hz.mem_busy) begin
          // Full freeze; a pending redirect stays in EX and fires once memory is ready.
          hz.stg_en = '0;
        end else if (hz.ex_redirect) begin
          hz.pc_enable    = 1'b1;
          hz.pc_sel       = 1'b1;
          hz.stg_fl[1:0]  = 2'b11;
        end else if (load_use) begin
          hz.stg_en[0] = 1'b0;
          hz.stg_fl[1] = 1'b1;
        end else begin
          hz.pc_enable = 1'b1;
        end
      end
      default: state_next = ST_RESET;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic             stall_hit, flush_hit;

  assign stall_hit = (state_reg == ST_RUN) &&
                     (hz.mem_busy || (!hz.ex_redirect && load_use));
  assign flush_hit = (state_reg == ST_RUN) && !hz.mem_busy && hz.ex_redirect;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_hit && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_hit && flush_cnt_reg != '1) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_reg;
  assign hz.flush_cnt = flush_cnt_reg;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven scoreboard bench for pipeline_hazard_ctrl (NSTAGES=5); checks counters when
// HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl_if #(.NSTAGES(5), .REG_ADDR_W(5), .CNT_W(32)) bus();

  pipeline_hazard_ctrl #(.NSTAGES(5), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (bus)
  );

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1, rs2, ex_rd;
    logic        ldm;
    logic [4:0]  mem_rd;
    logic        mem_we;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        redir, busy;
    logic [13:0] exp;   // {pc_enable, pc_sel, stg_en[3:0], stg_fl[3:0], fwd_a, fwd_b}
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [13:0] sb_q[$];
  vec_t tbl[$];

  function automatic logic [13:0] ex(logic pc, logic sel, logic [3:0] en, logic [3:0] fl,
                                     logic [1:0] fa, logic [1:0] fb);
    return {pc, sel, en, fl, fa, fb};
  endfunction

  function automatic vec_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] ex_rd,
                              logic ldm, logic [4:0] mem_rd, logic mem_we, logic [4:0] wb_rd,
                              logic wb_we, logic redir, logic busy, logic [13:0] e);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.ex_rd = ex_rd; v.ldm = ldm;
    v.mem_rd = mem_rd; v.mem_we = mem_we; v.wb_rd = wb_rd; v.wb_we = wb_we;
    v.redir = redir; v.busy = busy; v.exp = e;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name);
    logic [13:0] got, want;
    @(negedge CLK);
    RST = v.rst;
    bus.de_rs1 = v.rs1; bus.de_rs2 = v.rs2; bus.ex_rd = v.ex_rd; bus.ex_mem_rd = v.ldm;
    bus.mem_rd = v.mem_rd; bus.mem_we = v.mem_we; bus.wb_rd = v.wb_rd; bus.wb_we = v.wb_we;
    bus.ex_redirect = v.redir; bus.mem_busy = v.busy;
    sb_q.push_back(v.exp);
    #2;
    got  = {bus.pc_enable, bus.pc_sel, bus.stg_en, bus.stg_fl, bus.fwd_a, bus.fwd_b};
    want = sb_q.pop_front();
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got pc_en/sel=%b%b en=%b fl=%b fwd=%b/%b, required pc_en/sel=%b%b en=%b fl=%b fwd=%b/%b",
               name, got[13], got[12], got[11:8], got[7:4], got[3:2], got[1:0],
               want[13], want[12], want[11:8], want[7:4], want[3:2], want[1:0]);
    end else begin
      $display("[TB] %s: pc_en/sel=%b%b en=%b fl=%b fwd=%b/%b ok",
               name, got[13], got[12], got[11:8], got[7:4], got[3:2], got[1:0]);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic chk_cnt(input string name, input logic [31:0] st, input logic [31:0] fl);
    tests++;
    if (bus.stall_cnt !== st || bus.flush_cnt !== fl) begin
      fails++;
      $display("FAIL %s: got stall_cnt=%0d flush_cnt=%0d, required %0d/%0d",
               name, bus.stall_cnt, bus.flush_cnt, st, fl);
    end else begin
      $display("[TB] %s: stall_cnt=%0d flush_cnt=%0d ok", name, bus.stall_cnt, bus.flush_cnt);
    end
  endtask
`endif

  localparam logic [13:0] RST_O = 14'b0_0_1111_1110_00_00;
  localparam logic [13:0] DRN_O = 14'b1_0_1111_1110_00_00;
  localparam logic [13:0] RUN_O = 14'b1_0_1111_0000_00_00;
  localparam logic [13:0] LU_O  = 14'b0_0_1110_0010_00_00;
  localparam logic [13:0] RD_O  = 14'b1_1_1111_0011_00_00;
  localparam logic [13:0] FRZ_O = 14'b0_0_0000_0000_00_00;

  initial begin
    bus.de_rs1 = '0; bus.de_rs2 = '0; bus.ex_rd = '0; bus.ex_mem_rd = 1'b0;
    bus.mem_rd = '0; bus.mem_we = 1'b0; bus.wb_rd = '0; bus.wb_we = 1'b0;
    bus.ex_redirect = 1'b0; bus.mem_busy = 1'b0;
    repeat (2) @(posedge CLK);

    // Reset and drain with hazards asserted: they must be ignored.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 5, 5, 5, 1, 5, 1, 5, 1, 1, 1, RST_O));
    tbl.push_back(mk(1, 5, 5, 5, 1, 5, 1, 5, 1, 1, 1, RST_O));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 5, 5, 5, 1, 5, 1, 5, 1, 1, 1, DRN_O));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O));
    tbl.push_back(mk(1, 0, 5, 5, 1, 0, 0, 0, 0, 0, 0, LU_O));
    tbl.push_back(mk(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, LU_O));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, RUN_O));
    tbl.push_back(mk(1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, RUN_O));
    tbl.push_back(mk(1, 0, 5, 5, 1, 0, 0, 0, 0, 1, 0, RD_O));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ_O));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RD_O));
    tbl.push_back(mk(1, 0, 5, 5, 1, 0, 0, 0, 0, 0, 1, FRZ_O));
    tbl.push_back(mk(1, 7, 0, 0, 0, 7, 1, 7, 1, 0, 0, ex(1, 0, 4'hf, 4'h0, 2'b01, 2'b00)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 7, 1, 0, 0, RUN_O));
    tbl.push_back(mk(1, 0, 9, 0, 0, 9, 0, 9, 1, 0, 0, ex(1, 0, 4'hf, 4'h0, 2'b00, 2'b10)));
    tbl.push_back(mk(1, 3, 3, 0, 0, 3, 1, 4, 1, 0, 0, ex(1, 0, 4'hf, 4'h0, 2'b01, 2'b01)));
    tbl.push_back(mk(1, 4, 4, 0, 0, 3, 1, 4, 1, 0, 0, ex(1, 0, 4'hf, 4'h0, 2'b10, 2'b10)));
    tbl.push_back(mk(1, 6, 5, 5, 1, 6, 1, 0, 0, 0, 0, ex(0, 0, 4'b1110, 4'b0010, 2'b01, 2'b00)));
    tbl.push_back(mk(1, 6, 0, 0, 0, 6, 1, 0, 0, 0, 1, ex(0, 0, 4'h0, 4'h0, 2'b01, 2'b00)));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Mid-RUN reset: RUN outputs this cycle, RESET outputs from the next edge.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O), "midrun_rst_same_cycle");
    step(mk(0, 0, 5, 5, 1, 0, 0, 0, 0, 1, 0, RST_O), "midrun_rst_next");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST_O), "rerelease");
    for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DRN_O), $sformatf("redrain%0d", i));
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("cnt_after_drain", 32'd0, 32'd0);
`endif
    for (int i = 0; i < 3; i++) step(mk(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, LU_O), $sformatf("cnt_lu%0d", i));
    for (int i = 0; i < 2; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RD_O), $sformatf("cnt_rd%0d", i));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O), "cnt_idle");
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("cnt_3_2", 32'd3, 32'd2);
`endif
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O), "cnt_rst_assert");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST_O), "cnt_rst_state");
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("cnt_cleared", 32'd0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
